fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Round-robin write-port arbiter that shares the single write port of the synchronous FIFO among `NUM_REQ` requesters. Each requester offers data on a valid/ready handshake. The arbiter grants bursts of up to `MAX_BURST` beats and drives the FIFO's `i_wren`/`i_wrdata` from registers. It throttles on the FIFO's `o_full`/`o_alm_full` flags so the FIFO never overflows. It sits between the producer agents and the FIFO write side, in the same clock domain.

## Interface
Parameters:
- `DATA_W`, default `` `DATA_W `` (8): data width; must equal the FIFO data width.
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `MAX_BURST`, default 4: maximum beats per grant, 1..16.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester data valid.
- `req_data`  in  NUM_REQ*DATA_W  requester i occupies `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NUM_REQ  per-requester ready; at most one bit high.
- `fifo_full`  in  1  FIFO `o_full`.
- `fifo_alm_full`  in  1  FIFO `o_alm_full`. Integration requirement: it must be high whenever fill is ≥ DEPTH-1.
- `i_wren`  out  1  FIFO write enable, registered.
- `i_wrdata`  out  DATA_W  FIFO write data, registered.
- `grant_id`  out  $clog2(NUM_REQ)  current or last owner, registered.
- `busy`  out  1  high while in BURST.

## Operation
- A beat is accepted when `req_valid[i] && req_ready[i]` at a posedge.
- FSM has two states, IDLE and BURST. Registers:
  - `owner`
  - `rr_ptr`
  - `beat_cnt`, width $clog2(MAX_BURST+1)
- IDLE:
  - `req_ready` = 0.
  - If any `req_valid` is high and start is permitted, select the first valid index searching upward from `rr_ptr`, modulo NUM_REQ.
  - On selection: `owner` ← index, `grant_id` ← index, `beat_cnt` ← 0, go to BURST.
  - Start is permitted when `!fifo_full`, further gated by Configuration.
- BURST:
  - `req_ready[owner] = !fifo_full && !(i_wren && fifo_alm_full)`, plus any Configuration gating. All other ready bits are 0.
  - The `i_wren && fifo_alm_full` term covers the one-cycle lag of the registered write.
  - On an accepted beat: `i_wren` ← 1, `i_wrdata` ← owner's slice, `beat_cnt` ← `beat_cnt`+1. Otherwise `i_wren` ← 0 and `i_wrdata` holds.
- Exit BURST → IDLE, with `rr_ptr` ← (`owner`+1) mod NUM_REQ, when either:
  - the accepted beat brings `beat_cnt` to MAX_BURST, or
  - `req_valid[owner]` is low in any BURST cycle.
- Stalls caused by `fifo_full` do not end a burst. `beat_cnt` is preserved across them.
- IDLE always lasts at least one cycle between bursts, including when the same requester is re-granted.
- `busy` = (state == BURST).

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `owner` 0, `beat_cnt` 0.
  - `i_wren` 0, `i_wrdata` 0, `grant_id` 0, `busy` 0, `req_ready` 0.
- `req_ready` is combinational from state registers, `fifo_full`, `fifo_alm_full` and `i_wren`. It has no combinational path from `req_valid`.
- Latency:
  - valid seen in IDLE at edge N → BURST and ready from cycle N+1;
  - first beat accepted at edge N+1 → `i_wren` high at cycle N+2.
  - Back-to-back beats produce consecutive `i_wren` cycles.
- `rr_ptr` wraps NUM_REQ-1 → 0.
- A requester dropping valid in the same cycle another raises it produces no grant change until IDLE.
- Reset mid-burst clears everything immediately. An accepted beat not yet written is dropped; the FIFO shares `rstn`, so this is consistent.

## Configuration
- `FIFO_ARB_ALM_THROTTLE_EN` defined:
  - IDLE→BURST additionally requires `!fifo_alm_full`.
  - In BURST, `req_ready` is additionally gated by `!fifo_alm_full`. The arbiter stops one entry early and leaves headroom for other writers or debug.
- Not defined: only the `fifo_full` and lag-term gating above applies.

## Test plan
Use DATA_W=8, NUM_REQ=4, MAX_BURST=4.
- Reset: assert `rstn`=0 mid-burst → all outputs 0 asynchronously. After release, the first grant goes to the lowest valid index ≥ 0.
- Single requester: requester 2 holds valid with data 0x10..0x15 → `i_wren` for 0x10..0x13 on 4 consecutive cycles, then 1 IDLE cycle. Requester 2 is re-granted, then 0x14, 0x15 are written. `grant_id`=2 throughout.
- Fairness: all four requesters continuously valid → grant order 0,1,2,3,0, each with exactly 4 beats, and one IDLE cycle between bursts.
- Full stall: `fifo_full`=1 after beat 2 of a burst for 3 cycles → `req_ready`=0 and `i_wren`=0 one cycle later. Beats 3 and 4 complete after release with no duplicate or lost data.
- Early end: requester 1 drops valid after 2 beats → BURST exits, `rr_ptr`=2, and the next valid requester ≥ 2 is granted.
- Macro: `fifo_alm_full`=1, `fifo_full`=0, requester 0 valid in IDLE → no grant with `FIFO_ARB_ALM_THROTTLE_EN`; grant within 1 cycle without it.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Optional macro FIFO_ARB_ALM_THROTTLE_EN: starts and beats are also held off by fifo_alm_full.
`ifndef DATA_W
`define DATA_W 8
`endif

module fifo_wr_arb #(
  parameter int DATA_W    = `DATA_W,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  input  logic                       fifo_alm_full,
  output logic                       i_wren,
  output logic [DATA_W-1:0]          i_wrdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam int SW  = IDW + 1;
  localparam logic [SW-1:0]      NR_S     = SW'(NUM_REQ);
  localparam logic [IDW-1:0]     LAST_ID  = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]      MAX_CNT  = CW'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
`ifdef FIFO_ARB_ALM_THROTTLE_EN
  localparam logic ALM_THROTTLE = 1'b1;
`else
  localparam logic ALM_THROTTLE = 1'b0;
`endif

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              i_wren_q, i_wren_d;
  logic [DATA_W-1:0] i_wrdata_q, i_wrdata_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;

  logic              start_ok_s;
  logic              beat_ok_s;
  logic              accept_s;
  logic [CW-1:0]     beat_next_s;
  logic              found_s;
  logic [IDW-1:0]    sel_s;
  logic [DATA_W-1:0] req_slice_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_slice_s[g] = req_data[g*DATA_W +: DATA_W];
  end

  // i_wren_q still high means one write is in flight that alm_full does not yet reflect
  assign beat_ok_s   = !fifo_full && !(i_wren_q && fifo_alm_full) && !(ALM_THROTTLE && fifo_alm_full);
  assign start_ok_s  = !fifo_full && !(ALM_THROTTLE && fifo_alm_full);
  assign accept_s    = req_valid[owner_q] && beat_ok_s;
  assign beat_next_s = beat_cnt_q + CW'(1);

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    logic [SW-1:0] idx_v;
    logic          hit_v;
    found_s = 1'b0;
    sel_s   = rr_ptr_q;
    idx_v   = '0;
    hit_v   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v   = {1'b0, rr_ptr_q} + SW'(k);
      idx_v   = (idx_v >= NR_S) ? (idx_v - NR_S) : idx_v;
      hit_v   = req_valid[idx_v[IDW-1:0]];
      sel_s   = (hit_v && !found_s) ? idx_v[IDW-1:0] : sel_s;
      found_s = found_s | hit_v;
    end
  end

  // State register and registered write-port outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      i_wren_q   <= 1'b0;
      i_wrdata_q <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      i_wren_q   <= i_wren_d;
      i_wrdata_q <= i_wrdata_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Next-state: grant in IDLE, count beats in BURST, leave on full burst or dropped valid
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    i_wren_d   = 1'b0;
    i_wrdata_d = i_wrdata_q;
    grant_id_d = grant_id_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s && start_ok_s) begin
          state_d    = ST_BURST;
          owner_d    = sel_s;
          grant_id_d = sel_s;
          beat_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (accept_s) begin
          i_wren_d   = 1'b1;
          i_wrdata_d = req_slice_s[owner_q];
          beat_cnt_d = beat_next_s;
        end else begin
          i_wren_d = 1'b0;
        end
        // fifo_full stalls keep the burst and its beat count
        if ((accept_s && (beat_next_s == MAX_CNT)) || !req_valid[owner_q]) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (owner_q == LAST_ID) ? '0 : (owner_q + IDW'(1));
        end else begin
          state_d = ST_BURST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    if ((state_q == ST_BURST) && beat_ok_s) begin
      req_ready = ONE_HOT0 << owner_q;
    end else begin
      req_ready = '0;
    end
    busy = (state_q == ST_BURST);
  end

  assign i_wren   = i_wren_q;
  assign i_wrdata = i_wrdata_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios with literal expectations,
// then randomized traffic against a FIFO fill model, all checked against a behavioural model.
module tb_fifo_wr_arb;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int IW = 2;
  localparam int DEPTH = 8;
`ifdef FIFO_ARB_ALM_THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_alm_full = 1'b0;
  logic            i_wren;
  logic [DW-1:0]   i_wrdata;
  logic [IW-1:0]   grant_id;
  logic            busy;

  fifo_wr_arb #(.DATA_W(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_alm_full(fifo_alm_full),
    .i_wren(i_wren), .i_wrdata(i_wrdata), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state (spec-level view of the arbiter)
  bit           m_busy;
  int           m_owner, m_rr, m_beats, m_gid;
  bit           m_wren;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] exp_q[$];

  // producers, FIFO fill model and DUT observation logs
  logic [DW-1:0] pd[NR];
  int            nacc[NR];
  bit            rnd_mode = 1'b0;
  bit            use_fifo = 1'b0;
  int            fill = 0;
  int            cyc = 0;
  bit            prev_busy = 1'b0;
  logic [DW-1:0] wlog[$];
  int            wcyc[$];
  int            dlog_g[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] m_ready();
    logic [NR-1:0] r;
    bit ok;
    r = '0;
    ok = !fifo_full && !(m_wren && fifo_alm_full) && !(THR && fifo_alm_full);
    if (m_busy && ok) r[m_owner] = 1'b1;
    return r;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_owner = 0; m_rr = 0; m_beats = 0; m_gid = 0;
    m_wren = 0; m_wdata = '0;
    exp_q.delete();
  endtask

  // one clock of the arbiter rules, applied with the inputs present before the edge
  task automatic m_step();
    logic [NR-1:0] rdy;
    bit acc, found;
    int idx;
    rdy = m_ready();
    if (!m_busy) begin
      m_wren = 0;
      found = 0;
      if (req_valid != '0 && !fifo_full && !(THR && fifo_alm_full)) begin
        for (int k = 0; k < NR; k++) begin
          idx = (m_rr + k) % NR;
          if (!found && req_valid[idx]) begin
            found = 1; m_owner = idx;
          end
        end
        m_gid = m_owner; m_beats = 0; m_busy = 1;
      end
    end else begin
      acc = req_valid[m_owner] && rdy[m_owner];
      m_wren = acc;
      if (acc) begin
        m_wdata = req_data[m_owner*DW +: DW];
        exp_q.push_back(m_wdata);
        m_beats++;
      end
      if ((acc && m_beats == MB) || !req_valid[m_owner]) begin
        m_busy = 0;
        m_rr = (m_owner + 1) % NR;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pd[i];
  endtask

  task automatic clear_logs();
    wlog.delete(); wcyc.delete(); dlog_g.delete();
    for (int i = 0; i < NR; i++) nacc[i] = 0;
    cyc = 0; prev_busy = 0; fill = 0;
  endtask

  // called at a negedge with inputs set; checks, steps one clock, returns at the next negedge
  task automatic tick();
    logic [NR-1:0] acc;
    bit w, pop;
    #1;
    chk("req_ready", req_ready, m_ready());
    chk("i_wren", i_wren, m_wren);
    chk("i_wrdata", i_wrdata, m_wdata);
    chk("grant_id", grant_id, m_gid);
    chk("busy", busy, m_busy);
    if (i_wren) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("sb_data", i_wrdata, exp_q.pop_front());
    end
    acc = req_valid & req_ready;
    w = i_wren;
    pop = use_fifo && (fill > 0) && ($urandom_range(9) < 4);
    @(posedge clk);
    m_step();
    if (use_fifo) begin
      if (w) chk("fifo_no_overflow", fill < DEPTH, 1);
      fill = fill + int'(w) - int'(pop);
      if (fill > DEPTH) fill = DEPTH;
    end
    cyc++;
    @(negedge clk);
    if (i_wren) begin wlog.push_back(i_wrdata); wcyc.push_back(cyc); end
    if (busy && !prev_busy) dlog_g.push_back(int'(grant_id));
    prev_busy = busy;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        nacc[i]++;
        pd[i] = rnd_mode ? DW'($urandom) : pd[i] + DW'(1);
      end
      if (rnd_mode) begin
        if (req_valid[i]) begin
          if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(1) == 0) begin
          req_valid[i] = 1'b1;
          pd[i] = DW'($urandom);
        end
      end
    end
    if (use_fifo) begin
      fifo_full = (fill == DEPTH);
      fifo_alm_full = (fill >= DEPTH - 1);
    end
    drive();
  endtask

  // asserted at a negedge so the clear is seen between clock edges
  task automatic do_reset();
    rstn = 1'b0;
    m_reset();
    #1;
    chk("rst_i_wren", i_wren, 0);
    chk("rst_i_wrdata", i_wrdata, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    clear_logs();
  endtask

  initial begin
    int n;
    for (int i = 0; i < NR; i++) begin pd[i] = '0; nacc[i] = 0; end
    m_reset();
    @(negedge clk);
    do_reset();

    // reset mid-burst, then first grant goes to lowest valid index
    pd[3] = 8'hA5; req_valid = 4'b1000; drive();
    repeat (4) tick();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_wdata", i_wrdata, 8'hA7);
    do_reset();
    pd[1] = 8'h70; pd[3] = 8'h90; req_valid = 4'b1010; drive();
    n = 0;
    while (dlog_g.size() == 0 && n < 10) begin tick(); n++; end
    chk("rst_first_grant_seen", dlog_g.size(), 1);
    if (dlog_g.size() > 0) chk("rst_first_grant", dlog_g[0], 1);

    // single requester: 4-beat burst, one IDLE cycle, re-grant for the rest
    req_valid = '0;
    do_reset();
    pd[2] = 8'h10; req_valid = 4'b0100; drive();
    n = 0;
    while (nacc[2] < 6 && n < 40) begin
      tick(); n++;
      if (nacc[2] >= 6) req_valid = '0;
    end
    repeat (3) tick();
    chk("single_nwrites", wlog.size(), 6);
    chk("single_ngrants", dlog_g.size(), 2);
    for (int k = 0; k < 6 && k < wlog.size(); k++) begin
      int offs[6] = '{0, 1, 2, 3, 5, 6};
      chk("single_data", wlog[k], 32'h10 + k);
      chk("single_timing", wcyc[k] - wcyc[0], offs[k]);
    end
    for (int k = 0; k < dlog_g.size(); k++) chk("single_grant", dlog_g[k], 2);

    // fairness: all requesters valid
    do_reset();
    for (int i = 0; i < NR; i++) pd[i] = DW'(i * 16);
    req_valid = 4'hF; drive();
    n = 0;
    while (wlog.size() < 20 && n < 60) begin tick(); n++; end
    req_valid = '0;
    chk("fair_nwrites", wlog.size() >= 20, 1);
    chk("fair_ngrants", dlog_g.size() >= 5, 1);
    for (int j = 0; j < 5 && j < dlog_g.size(); j++) chk("fair_grant", dlog_g[j], j % NR);
    for (int k = 0; k < 20 && k < wlog.size(); k++) begin
      chk("fair_data", wlog[k], ((k / 4) % NR) * 16 + ((k / 4) / NR) * 4 + (k % 4));
      chk("fair_timing", wcyc[k] - wcyc[0], (k / 4) * 5 + (k % 4));
    end

    // full stall after beat 2 for 3 cycles
    do_reset();
    pd[0] = 8'h20; req_valid = 4'b0001; drive();
    n = 0;
    while (nacc[0] < 2 && n < 20) begin tick(); n++; end
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_ready", req_ready, 0);
      chk("stall_wren", i_wren, (s == 0) ? 1 : 0);
      tick();
    end
    fifo_full = 1'b0;
    n = 0;
    while (nacc[0] < 4 && n < 20) begin tick(); n++; end
    req_valid = '0;
    repeat (3) tick();
    chk("stall_nwrites", wlog.size(), 4);
    for (int k = 0; k < 4 && k < wlog.size(); k++) chk("stall_data", wlog[k], 32'h20 + k);
    chk("stall_ngrants", dlog_g.size(), 1);

    // early end: requester 1 drops after 2 beats while 0 and 3 raise
    do_reset();
    pd[0] = 8'h40; pd[1] = 8'h30; pd[3] = 8'h50; req_valid = 4'b0010; drive();
    n = 0;
    while (nacc[1] < 2 && n < 20) begin tick(); n++; end
    req_valid = 4'b1001;
    n = 0;
    while (dlog_g.size() < 2 && n < 20) begin tick(); n++; end
    req_valid = '0;
    chk("early_ngrants", dlog_g.size(), 2);
    if (dlog_g.size() >= 2) begin
      chk("early_grant0", dlog_g[0], 1);
      chk("early_grant1", dlog_g[1], 3);
    end
    if (wlog.size() >= 2) begin
      chk("early_data0", wlog[0], 8'h30);
      chk("early_data1", wlog[1], 8'h31);
    end

    // almost-full at IDLE: start depends on the throttle option
    do_reset();
    fifo_alm_full = 1'b1; pd[0] = 8'h60; req_valid = 4'b0001; drive();
    tick();
    chk("alm_start_busy", busy, THR ? 32'd0 : 32'd1);
    fifo_alm_full = 1'b0; req_valid = '0;
    repeat (3) tick();

    // randomized traffic against a FIFO fill model
    do_reset();
    use_fifo = 1'b1; rnd_mode = 1'b1;
    fifo_full = 1'b0; fifo_alm_full = 1'b0;
    repeat (3000) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
